// File: rtl/usb_pkt_rx_if.sv
// Purpose: bit-stream input and decoded-packet output bundle of the USB packet receiver.
// Ports (signals):
//   bit_in, bit_en, eop      serial input side (driven by the line front end)
//   rx_busy                  decoder is not hunting for SYNC
//   pkt_valid                one-cycle pulse qualifying all pkt_* and err_*
//   pkt_kind/pid/addr/endp   decoded packet header fields
//   pkt_data, data_len       DATA payload (byte0 in [7:0]) and its byte count
//   err_pid/err_crc/err_len  packet error flags
// Modports: master = bit-stream source / packet consumer, slave = decoder.
interface usb_pkt_rx_if #(
    parameter int unsigned DATA_BYTES = 8
);
    localparam int unsigned LEN_W = $clog2(DATA_BYTES + 1);

    logic                    bit_in;
    logic                    bit_en;
    logic                    eop;
    logic                    rx_busy;
    logic                    pkt_valid;
    logic [1:0]              pkt_kind;
    logic [3:0]              pkt_pid;
    logic [6:0]              pkt_addr;
    logic [3:0]              pkt_endp;
    logic [DATA_BYTES*8-1:0] pkt_data;
    logic [LEN_W-1:0]        data_len;
    logic                    err_pid;
    logic                    err_crc;
    logic                    err_len;

    modport master (
        output bit_in, bit_en, eop,
        input  rx_busy, pkt_valid, pkt_kind, pkt_pid, pkt_addr, pkt_endp,
               pkt_data, data_len, err_pid, err_crc, err_len
    );

    modport slave (
        input  bit_in, bit_en, eop,
        output rx_busy, pkt_valid, pkt_kind, pkt_pid, pkt_addr, pkt_endp,
               pkt_data, data_len, err_pid, err_crc, err_len
    );
endinterface

// File: rtl/usb_pkt_rx.sv
// Purpose: serial-to-packet decoder. Hunts SYNC in the de-stuffed bit stream,
// validates the PID, captures token fields or DATA payload, checks CRC5/CRC16
// by residue and emits one registered packet per pkt_valid pulse.
// Ports:
//   clk     clock
//   rst_b   asynchronous active-low reset
//   io_rx   usb_pkt_rx_if slave: bit_in/bit_en/eop in, decoded packet out
module usb_pkt_rx #(
    parameter int unsigned DATA_BYTES = 8,
    parameter logic [7:0]  SYNC_PAT   = 8'b0000_0001
) (
    input  logic        clk,
    input  logic        rst_b,
    usb_pkt_rx_if.slave io_rx
);
    localparam int unsigned BUF_W = DATA_BYTES * 8 + 16;
    localparam int unsigned CNT_W = $clog2(BUF_W + 2);
    localparam int unsigned LEN_W = $clog2(DATA_BYTES + 1);
    localparam int unsigned DAT_W = DATA_BYTES * 8;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [2:0] ST_HUNT  = 3'd0;
    localparam logic [2:0] ST_PID   = 3'd1;
    localparam logic [2:0] ST_TOKEN = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_HS    = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    // One LFSR step: preset-all-ones CRC, bits fed in arrival order.
    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
        return {c[3:0], 1'b0} ^ (((b ^ c[4]) == 1'b1) ? 5'b00101 : 5'b00000);
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ (((b ^ c[15]) == 1'b1) ? 16'h8005 : 16'h0000);
    endfunction

    logic [2:0]       r_state, w_state_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [4:0]       r_crc5, w_crc5_nxt;
    logic [15:0]      r_crc16, w_crc16_nxt;
    logic [BUF_W-1:0] r_buf, w_buf_nxt;
    logic             r_lerr, w_lerr_nxt;
    logic [3:0]       r_pid, w_pid_nxt;

    logic             r_busy, r_valid, r_epid, r_ecrc, r_elen;
    logic [1:0]       r_kind;
    logic [3:0]       r_opid;
    logic [6:0]       r_addr;
    logic [3:0]       r_endp;
    logic [DAT_W-1:0] r_data;
    logic [LEN_W-1:0] r_dlen;

    logic             w_bit_v, w_emit, w_epid, w_ecrc, w_elen;
    logic [1:0]       w_kind;
    logic [3:0]       w_opid;
    logic [6:0]       w_addr;
    logic [3:0]       w_endp;
    logic [LEN_W-1:0] w_dlen;
    logic [7:0]       w_hunt, w_pid_byte;
    logic [CNT_W-1:0] w_cnt_inc, w_nm16;
    logic [BUF_W-1:0] w_buf_wr;

    // Next-state, datapath and packet-result logic.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_crc5_nxt  = r_crc5;
        w_crc16_nxt = r_crc16;
        w_buf_nxt   = r_buf;
        w_lerr_nxt  = r_lerr;
        w_pid_nxt   = r_pid;
        w_emit      = 1'b0;
        w_kind      = 2'b00;
        w_opid      = r_pid;
        w_addr      = 7'h00;
        w_endp      = 4'h0;
        w_dlen      = '0;
        w_epid      = 1'b0;
        w_ecrc      = 1'b0;
        w_elen      = 1'b0;

        // eop wins over a coincident bit
        w_bit_v    = io_rx.bit_en & ~io_rx.eop;
        w_hunt     = {r_shift[6:0], io_rx.bit_in};
        w_pid_byte = {io_rx.bit_in, r_shift[7:1]};
        w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
        w_nm16     = r_cnt - CNT_W'(16);
        w_buf_wr   = (r_buf & ~(BUF_W'(1'b1) << r_cnt)) | (BUF_W'(io_rx.bit_in) << r_cnt);

        case (r_state)
            ST_HUNT: begin
                if (w_bit_v) begin
                    w_shift_nxt = w_hunt;
                    if (w_hunt == SYNC_PAT) begin
                        w_state_nxt = ST_PID;
                        w_shift_nxt = 8'h00;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            ST_PID: begin
                if (io_rx.eop) begin
                    w_emit = 1'b1;
                    w_elen = 1'b1;
                    w_opid = 4'h0;
                end else if (w_bit_v) begin
                    w_shift_nxt = w_pid_byte;
                    w_cnt_nxt   = w_cnt_inc;
                    if (r_cnt == CNT_W'(7)) begin
                        w_pid_nxt   = w_pid_byte[3:0];
                        w_cnt_nxt   = '0;
                        w_crc5_nxt  = 5'h1F;
                        w_crc16_nxt = 16'hFFFF;
                        w_lerr_nxt  = 1'b0;
                        if ((w_pid_byte[7:4] != ~w_pid_byte[3:0]) || (w_pid_byte[1:0] == 2'b00)) begin
                            w_state_nxt = ST_DRAIN;
                        end else begin
                            case (w_pid_byte[1:0])
                                2'b01:   w_state_nxt = ST_TOKEN;
                                2'b11:   w_state_nxt = ST_DATA;
                                default: w_state_nxt = ST_HS;
                            endcase
                        end
                    end
                end
            end
            ST_TOKEN: begin
                if (io_rx.eop) begin
                    w_emit = 1'b1;
                    w_kind = 2'b01;
                    w_addr = r_buf[6:0];
                    w_endp = r_buf[10:7];
                    w_elen = (r_cnt != CNT_W'(16));
                    w_ecrc = !w_elen && (r_crc5 != 5'b01100);
                end else if (w_bit_v) begin
                    if (r_cnt < CNT_W'(BUF_W)) w_buf_nxt = w_buf_wr;
                    w_crc5_nxt = crc5_step(r_crc5, io_rx.bit_in);
                    w_cnt_nxt  = w_cnt_inc;
                end
            end
            ST_DATA: begin
                if (io_rx.eop) begin
                    w_emit = 1'b1;
                    w_kind = 2'b11;
                    w_elen = r_lerr || (r_cnt < CNT_W'(16)) || (r_cnt[2:0] != 3'b000)
                             || (r_cnt > CNT_W'(BUF_W));
                    w_dlen = w_elen ? '0 : LEN_W'(w_nm16 >> 3);
                    w_ecrc = !w_elen && (r_crc16 != 16'h800D);
                end else if (w_bit_v) begin
                    if (r_cnt < CNT_W'(BUF_W)) w_buf_nxt = w_buf_wr;
                    else                       w_lerr_nxt = 1'b1;
                    w_crc16_nxt = crc16_step(r_crc16, io_rx.bit_in);
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            ST_HS: begin
                if (io_rx.eop) begin
                    w_emit = 1'b1;
                    w_kind = 2'b10;
                    w_elen = r_lerr;
                end else if (w_bit_v) begin
                    w_lerr_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                // only reached on a PID failure
                if (io_rx.eop) begin
                    w_emit = 1'b1;
                    w_epid = 1'b1;
                end
            end
            default: w_state_nxt = ST_HUNT;
        endcase

        // Back to HUNT; all-ones history forces a full SYNC before the next match.
        if (w_emit) begin
            w_state_nxt = ST_HUNT;
            w_shift_nxt = 8'hFF;
        end
    end

    // State, datapath and registered packet outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_HUNT;
            r_shift <= '0;
            r_cnt   <= '0;
            r_crc5  <= '0;
            r_crc16 <= '0;
            r_buf   <= '0;
            r_lerr  <= 1'b0;
            r_pid   <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_kind  <= '0;
            r_opid  <= '0;
            r_addr  <= '0;
            r_endp  <= '0;
            r_data  <= '0;
            r_dlen  <= '0;
            r_epid  <= 1'b0;
            r_ecrc  <= 1'b0;
            r_elen  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_crc5  <= w_crc5_nxt;
            r_crc16 <= w_crc16_nxt;
            r_buf   <= w_buf_nxt;
            r_lerr  <= w_lerr_nxt;
            r_pid   <= w_pid_nxt;
            r_busy  <= (w_state_nxt != ST_HUNT);
            r_valid <= w_emit;
            if (w_emit) begin
                r_kind <= w_kind;
                r_opid <= w_opid;
                r_addr <= w_addr;
                r_endp <= w_endp;
                r_data <= r_buf[DAT_W-1:0];
                r_dlen <= w_dlen;
                r_epid <= w_epid;
                r_ecrc <= w_ecrc;
                r_elen <= w_elen;
            end
        end
    end

    assign io_rx.rx_busy   = r_busy;
    assign io_rx.pkt_valid = r_valid;
    assign io_rx.pkt_kind  = r_kind;
    assign io_rx.pkt_pid   = r_opid;
    assign io_rx.pkt_addr  = r_addr;
    assign io_rx.pkt_endp  = r_endp;
    assign io_rx.pkt_data  = r_data;
    assign io_rx.data_len  = r_dlen;
    assign io_rx.err_pid   = r_epid;
    assign io_rx.err_crc   = r_ecrc;
    assign io_rx.err_len   = r_elen;
endmodule
